timing_scheduler_mc: RTL and testbench
======================================

Name: timing_scheduler_mc

Overview:
Multi-command successor to the single-beat instruction/write-data merger that sits between the host AXI-Stream channels and the command decoder. It accepts instructions of NUM_CMDS packed commands and independently buffers write-data beats in a WDATA_DEPTH-entry FIFO. Each WR command in an instruction consumes its own write-data beat, where the previous generation used one beat per instruction. The merged output carries one write-data slot per command; slots of non-WR commands are zero.

Parameters:
- NUM_CMDS, 4, commands per instruction (>=1)
- CMD_WIDTH, 32, bits per command
- OPCODE_LSB, 0, LSB of the opcode field within a command
- OPCODE_WIDTH, 3, opcode field width
- CMD_WR_CODE, 4, opcode value that marks a WR command
- WDATA_WIDTH, 512, bits per write-data beat
- WDATA_DEPTH, 4, write-data FIFO entries; power of 2 and >= NUM_CMDS (enforced by elaboration check)
- INSTR_WIDTH, NUM_CMDS*CMD_WIDTH, derived
- MERGED_WIDTH, INSTR_WIDTH+NUM_CMDS*WDATA_WIDTH, derived

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axis_instr_tdata  in  INSTR_WIDTH  instruction; command i occupies bits [i*CMD_WIDTH +: CMD_WIDTH]
- s_axis_instr_tvalid  in  1  instruction valid
- s_axis_instr_tready  out  1  instruction ready
- s_axis_wdata_tdata  in  WDATA_WIDTH  write-data beat
- s_axis_wdata_tvalid  in  1  write-data valid
- s_axis_wdata_tready  out  1  write-data ready
- m_axis_tdata  out  MERGED_WIDTH  [INSTR_WIDTH-1:0] = instruction; slot i = [INSTR_WIDTH + i*WDATA_WIDTH +: WDATA_WIDTH]
- m_axis_tvalid  out  1  merged output valid
- m_axis_tready  in  1  downstream ready
- wdata_level  out  $clog2(WDATA_DEPTH+1)  FIFO occupancy
- stall_wdata  out  1  held instruction is waiting for write data
- stall_cycles  out  32  saturating count of cycles with stall_wdata high

Behaviour:
- Reset rst is synchronous and active-high; clock is clk.
- Values during rst and on the cycle after it: instruction register invalid, FIFO empty, wdata_level=0, m_axis_tvalid=0, stall_wdata=0, stall_cycles=0. Both s_*_tready are forced to 0 while rst is high.
- rst asserted mid-operation discards the held instruction and all buffered beats. No partial output is produced.
- Instruction register holds one entry.
  - s_axis_instr_tready = !instr_valid || (m_axis_tvalid && m_axis_tready).
  - A capture at edge n makes the instruction visible on m_axis from cycle n+1.
- wr_mask[i] = (opcode of command i == CMD_WR_CODE), computed from the held instruction. wr_cnt = popcount(wr_mask), range 0..NUM_CMDS.
- m_axis_tvalid = instr_valid && (wr_cnt <= wdata_level).
  - Fully combinational from registered state.
  - Once asserted, it stays high and m_axis_tdata stays stable until the handshake.
- Slot mapping:
  - The k-th set bit of wr_mask, counting from command 0 upward, receives the k-th oldest FIFO entry.
  - Slots with wr_mask=0 are all-zero.
  - The instruction field passes through unmodified.
- Pop count: on output handshake, exactly wr_cnt entries are popped; wr_cnt=0 pops nothing.
- FIFO push:
  - s_axis_wdata_tready = (wdata_level < WDATA_DEPTH).
  - No pass-through: a full FIFO stays not-ready even if a pop occurs in the same cycle. Ready returns the cycle after the pop.
- Simultaneous push and pop: next level = level + push - wr_cnt. Read and write pointers wrap modulo WDATA_DEPTH.
- Instruction register on the same edge: capture overrides clear, so back-to-back instructions flow at one per cycle.
- stall_wdata = instr_valid && (wr_cnt > wdata_level).
- stall_cycles increments each cycle stall_wdata is high and saturates at 0xFFFF_FFFF.
- Beats may arrive before or after their instruction. Beats beyond current demand remain buffered for later instructions.
- No state machine beyond the valid flags and FIFO pointers. Throughput is one instruction per cycle when data is available.

Decomposition:
- Package timing_sched_pkg: CMD_WR_CODE and the other opcode localparams (ACT/PRE/RD/WR/NOP encodings), plus a function for extracting the opcode field.
- Sub-module sched_wdata_fifo:
  - Parameters WIDTH, DEPTH, NPOP.
  - Single push per cycle.
  - Variable pop of 0..NPOP entries per cycle.
  - Exposes the NPOP oldest entries in parallel, plus level.
- The top level owns the instruction register, wr_mask/wr_cnt logic, slot-compaction mux and stall counter.

Test Plan:
- No-WR instruction: opcodes {0,1,2,3} with m_tready=1. Expect output on the cycle after capture, all four slots zero, wdata_level unchanged at 0.
- Preload then issue: push A then B, then an instruction with WR in cmd1 and cmd3. Expect slot1=A, slot3=B, slots 0 and 2 zero, level 2->0 after handshake.
- Underrun stall: level=1, then an instruction with 3 WRs. Expect tvalid=0, stall_wdata=1 and stall_cycles incrementing. Push 2 beats; tvalid rises once level=3, and stall_cycles freezes at the stalled cycle count.
- FIFO full: 4 pushes with no instruction. Expect s_wdata_tready=0 at level=4. Issue a 1-WR instruction; ready returns one cycle after the pop, and simultaneous push+pop keeps level correct.
- Backpressure: m_tready=0 for 5 cycles with a valid held instruction. Expect m_tdata stable, s_instr_tready=0, no pops. Release m_tready; back-to-back instructions then issue at 1/cycle.
- Reset mid-operation: assert rst with 1 instruction held and level=3. Expect the next cycle tvalid=0, level=0, stall_cycles=0, with no spurious handshake.

Source files
------------

// File: rtl/timing_sched_pkg.sv
// rtl/timing_sched_pkg.sv - opcode encodings and field helpers for the timing scheduler
package timing_sched_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_PRE = 3'd2;
  localparam logic [2:0] OP_RD  = 3'd3;
  localparam logic [2:0] OP_WR  = 3'd4;

  localparam int CMD_WR_CODE = int'(OP_WR);

  // Opcode fields wider than 8 bits are not supported; commands wider than 64 bits
  // only need their low 64 bits to hold the opcode.
  function automatic logic [7:0] get_opcode(input logic [63:0] cmd, input int lsb, input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 8'((cmd >> lsb) & mask);
  endfunction

endpackage

// File: rtl/sched_wdata_fifo.sv
// rtl/sched_wdata_fifo.sv - write-data FIFO, single push, 0..NPOP pops, NPOP oldest entries visible
module sched_wdata_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  parameter int NPOP  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_valid,
  input  logic [WIDTH-1:0]                 push_data,
  output logic                             push_ready,
  input  logic [$clog2(NPOP+1)-1:0]        pop_cnt,
  output logic [NPOP*WIDTH-1:0]            head_data,
  output logic [$clog2(DEPTH+1)-1:0]       level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PMASK = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // No pass-through: a full FIFO refuses pushes even while it is being popped.
  assign push_ready = (32'(level) < DEPTH);

  // Storage write; push_valid is already qualified by push_ready upstream.
  always_ff @(posedge clk) begin
    if (push_valid) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH (power of two); level tracks push minus pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_valid) begin
        wr_ptr <= (wr_ptr + AW'(1)) & PMASK;
      end
      rd_ptr <= (rd_ptr + AW'(pop_cnt)) & PMASK;
      level  <= level + LW'(push_valid) - LW'(pop_cnt);
    end
  end

  // Present the NPOP oldest entries, oldest in slot 0.
  always_comb begin
    head_data = '0;
    for (int k = 0; k < NPOP; k++) begin
      head_data[k*WIDTH +: WIDTH] = mem[(rd_ptr + AW'(k)) & PMASK];
    end
  end

endmodule

// File: rtl/timing_scheduler_mc.sv
// rtl/timing_scheduler_mc.sv - merges multi-command instructions with per-WR write-data beats
module timing_scheduler_mc #(
  parameter int NUM_CMDS     = 4,
  parameter int CMD_WIDTH    = 32,
  parameter int OPCODE_LSB   = 0,
  parameter int OPCODE_WIDTH = 3,
  parameter int CMD_WR_CODE  = timing_sched_pkg::CMD_WR_CODE,
  parameter int WDATA_WIDTH  = 512,
  parameter int WDATA_DEPTH  = 4,
  parameter int INSTR_WIDTH  = NUM_CMDS*CMD_WIDTH,
  parameter int MERGED_WIDTH = INSTR_WIDTH + NUM_CMDS*WDATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [INSTR_WIDTH-1:0]               s_axis_instr_tdata,
  input  logic                                 s_axis_instr_tvalid,
  output logic                                 s_axis_instr_tready,
  input  logic [WDATA_WIDTH-1:0]               s_axis_wdata_tdata,
  input  logic                                 s_axis_wdata_tvalid,
  output logic                                 s_axis_wdata_tready,
  output logic [MERGED_WIDTH-1:0]              m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [$clog2(WDATA_DEPTH+1)-1:0]     wdata_level,
  output logic                                 stall_wdata,
  output logic [31:0]                          stall_cycles
);

  import timing_sched_pkg::get_opcode;

  localparam int CW = $clog2(NUM_CMDS+1);

  if (WDATA_DEPTH < NUM_CMDS || (WDATA_DEPTH & (WDATA_DEPTH - 1)) != 0) begin : g_depth_check
    $error("WDATA_DEPTH must be a power of 2 and at least NUM_CMDS");
  end

  logic [INSTR_WIDTH-1:0]             instr_q;
  logic                               instr_valid;
  logic [NUM_CMDS-1:0]                wr_mask;
  logic [CW-1:0]                      wr_cnt;
  logic [CW-1:0]                      pop_cnt;
  logic [$clog2(WDATA_DEPTH+1)-1:0]   fifo_level;
  logic                               fifo_ready;
  logic [NUM_CMDS*WDATA_WIDTH-1:0]    fifo_head;
  logic [NUM_CMDS*WDATA_WIDTH-1:0]    slots;
  logic [31:0]                        stall_cnt;
  logic                               data_ok;
  logic                               fire;

  sched_wdata_fifo #(
    .WIDTH (WDATA_WIDTH),
    .DEPTH (WDATA_DEPTH),
    .NPOP  (NUM_CMDS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (s_axis_wdata_tvalid && s_axis_wdata_tready),
    .push_data  (s_axis_wdata_tdata),
    .push_ready (fifo_ready),
    .pop_cnt    (pop_cnt),
    .head_data  (fifo_head),
    .level      (fifo_level)
  );

  // Decode which commands of the held instruction are writes and how many beats they need.
  always_comb begin
    wr_mask = '0;
    wr_cnt  = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      wr_mask[i] = (get_opcode(64'(instr_q[i*CMD_WIDTH +: CMD_WIDTH]), OPCODE_LSB, OPCODE_WIDTH)
                    == 8'(CMD_WR_CODE));
      wr_cnt = wr_cnt + CW'(wr_mask[i]);
    end
  end

  assign data_ok             = (32'(wr_cnt) <= 32'(fifo_level));
  assign m_axis_tvalid       = !rst && instr_valid && data_ok;
  assign stall_wdata         = !rst && instr_valid && !data_ok;
  assign fire                = m_axis_tvalid && m_axis_tready;
  assign pop_cnt             = fire ? wr_cnt : '0;
  assign s_axis_instr_tready = !rst && (!instr_valid || fire);
  assign s_axis_wdata_tready = !rst && fifo_ready;
  assign wdata_level         = rst ? '0 : fifo_level;
  assign stall_cycles        = rst ? '0 : stall_cnt;
  assign m_axis_tdata        = {slots, instr_q};

  // Compact FIFO entries onto WR slots: k-th WR command (from cmd 0 up) takes the k-th oldest beat.
  always_comb begin
    int k;
    slots = '0;
    k     = 0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (wr_mask[i]) begin
        slots[i*WDATA_WIDTH +: WDATA_WIDTH] = fifo_head[k*WDATA_WIDTH +: WDATA_WIDTH];
        k = k + 1;
      end
    end
  end

  // Single-entry instruction register; a new capture wins over the clear from a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr_q     <= '0;
    end else if (s_axis_instr_tvalid && s_axis_instr_tready) begin
      instr_valid <= 1'b1;
      instr_q     <= s_axis_instr_tdata;
    end else if (fire) begin
      instr_valid <= 1'b0;
    end
  end

  // Saturating count of cycles the held instruction waits for write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_wdata && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_timing_scheduler_mc.sv
// tb/tb_timing_scheduler_mc.sv - directed self-checking bench for timing_scheduler_mc
module tb_timing_scheduler_mc;

  localparam int NC = 4;
  localparam int CWD = 32;
  localparam int WW = 512;
  localparam int IW = NC*CWD;
  localparam int MW = IW + NC*WW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IW-1:0]   s_axis_instr_tdata = '0;
  logic            s_axis_instr_tvalid = 1'b0;
  logic            s_axis_instr_tready;
  logic [WW-1:0]   s_axis_wdata_tdata = '0;
  logic            s_axis_wdata_tvalid = 1'b0;
  logic            s_axis_wdata_tready;
  logic [MW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b0;
  logic [2:0]      wdata_level;
  logic            stall_wdata;
  logic [31:0]     stall_cycles;

  int checks = 0;
  int errors = 0;

  timing_scheduler_mc dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_instr_tdata  (s_axis_instr_tdata),
    .s_axis_instr_tvalid (s_axis_instr_tvalid),
    .s_axis_instr_tready (s_axis_instr_tready),
    .s_axis_wdata_tdata  (s_axis_wdata_tdata),
    .s_axis_wdata_tvalid (s_axis_wdata_tvalid),
    .s_axis_wdata_tready (s_axis_wdata_tready),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .wdata_level         (wdata_level),
    .stall_wdata         (stall_wdata),
    .stall_cycles        (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] beat(input logic [31:0] n);
    return {16{n ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [IW-1:0] mk(input logic [7:0] tag, input logic [2:0] o0,
                                        input logic [2:0] o1, input logic [2:0] o2, input logic [2:0] o3);
    logic [IW-1:0] r;
    logic [2:0] ops [4];
    ops[0] = o0; ops[1] = o1; ops[2] = o2; ops[3] = o3;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      r[i*CWD +: CWD] = {tag, 8'(i), 13'h0, ops[i]};
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] slot(input logic [MW-1:0] d, input int i);
    return d[IW + i*WW +: WW];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (s_axis_instr_tready !== 1'b0) begin errors++; $display("FAIL rst_instr_tready: got %b expected 0", s_axis_instr_tready); end
    checks++; if (s_axis_wdata_tready !== 1'b0) begin errors++; $display("FAIL rst_wdata_tready: got %b expected 0", s_axis_wdata_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (wdata_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", wdata_level); end
    checks++; if (stall_wdata !== 1'b0 || stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall: got %b/%0d expected 0/0", stall_wdata, stall_cycles); end
    rst = 1'b0;
    step();
    checks++; if (s_axis_instr_tready !== 1'b1 || s_axis_wdata_tready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b%b expected 11", s_axis_instr_tready, s_axis_wdata_tready); end
    checks++; if (m_axis_tvalid !== 1'b0 || wdata_level !== 3'd0) begin errors++; $display("FAIL post_rst_state: got tvalid %b level %0d expected 0 0", m_axis_tvalid, wdata_level); end
  endtask

  task automatic test_no_wr();
    logic [IW-1:0] ins;
    ins = mk(8'h01, 3'd0, 3'd1, 3'd2, 3'd3);
    m_axis_tready = 1'b1;
    s_axis_instr_tdata = ins;
    s_axis_instr_tvalid = 1'b1;
    step();
    s_axis_instr_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL nowr_tvalid: got %b expected 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata[IW-1:0] !== ins) begin errors++; $display("FAIL nowr_instr: got %h expected %h", m_axis_tdata[IW-1:0], ins); end
    checks++; if (m_axis_tdata[MW-1:IW] !== '0) begin errors++; $display("FAIL nowr_slots: got nonzero expected all zero"); end
    checks++; if (wdata_level !== 3'd0) begin errors++; $display("FAIL nowr_level: got %0d expected 0", wdata_level); end
    step();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL nowr_done: got tvalid %b expected 0", m_axis_tvalid); end
  endtask

  task automatic test_preload();
    logic [IW-1:0] ins;
    s_axis_wdata_tvalid = 1'b1;
    s_axis_wdata_tdata = beat(32'hA);
    step();
    s_axis_wdata_tdata = beat(32'hB);
    step();
    s_axis_wdata_tvalid = 1'b0;
    checks++; if (wdata_level !== 3'd2) begin errors++; $display("FAIL pre_level: got %0d expected 2", wdata_level); end
    ins = mk(8'h02, 3'd0, 3'd4, 3'd0, 3'd4);
    s_axis_instr_tdata = ins;
    s_axis_instr_tvalid = 1'b1;
    step();
    s_axis_instr_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL pre_tvalid: got %b expected 1", m_axis_tvalid); end
    checks++; if (slot(m_axis_tdata, 1) !== beat(32'hA)) begin errors++; $display("FAIL pre_slot1: got %h expected %h", slot(m_axis_tdata, 1), beat(32'hA)); end
    checks++; if (slot(m_axis_tdata, 3) !== beat(32'hB)) begin errors++; $display("FAIL pre_slot3: got %h expected %h", slot(m_axis_tdata, 3), beat(32'hB)); end
    checks++; if (slot(m_axis_tdata, 0) !== '0 || slot(m_axis_tdata, 2) !== '0) begin errors++; $display("FAIL pre_slot02: got nonzero expected zero"); end
    step();
    checks++; if (wdata_level !== 3'd0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL pre_after: got level %0d tvalid %b expected 0 0", wdata_level, m_axis_tvalid); end
  endtask

  task automatic test_underrun();
    s_axis_wdata_tvalid = 1'b1;
    s_axis_wdata_tdata = beat(32'hC);
    step();
    s_axis_wdata_tvalid = 1'b0;
    s_axis_instr_tdata = mk(8'h03, 3'd4, 3'd4, 3'd4, 3'd0);
    s_axis_instr_tvalid = 1'b1;
    step();
    s_axis_instr_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0 || stall_wdata !== 1'b1) begin errors++; $display("FAIL und_stall: got tvalid %b stall %b expected 0 1", m_axis_tvalid, stall_wdata); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL und_cnt0: got %0d expected 0", stall_cycles); end
    step(); step(); step();
    checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL und_cnt3: got %0d expected 3", stall_cycles); end
    s_axis_wdata_tvalid = 1'b1;
    s_axis_wdata_tdata = beat(32'hD);
    step();
    checks++; if (m_axis_tvalid !== 1'b0 || wdata_level !== 3'd2) begin errors++; $display("FAIL und_mid: got tvalid %b level %0d expected 0 2", m_axis_tvalid, wdata_level); end
    s_axis_wdata_tdata = beat(32'hE);
    step();
    s_axis_wdata_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1 || stall_wdata !== 1'b0) begin errors++; $display("FAIL und_release: got tvalid %b stall %b expected 1 0", m_axis_tvalid, stall_wdata); end
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL und_cnt5: got %0d expected 5", stall_cycles); end
    checks++; if (slot(m_axis_tdata, 0) !== beat(32'hC) || slot(m_axis_tdata, 1) !== beat(32'hD) || slot(m_axis_tdata, 2) !== beat(32'hE) || slot(m_axis_tdata, 3) !== '0) begin errors++; $display("FAIL und_slots: got %h expected %h in slot2", slot(m_axis_tdata, 2), beat(32'hE)); end
    step();
    checks++; if (stall_cycles !== 32'd5 || wdata_level !== 3'd0) begin errors++; $display("FAIL und_after: got cnt %0d level %0d expected 5 0", stall_cycles, wdata_level); end
  endtask

  task automatic test_full();
    logic [IW-1:0] ins2;
    m_axis_tready = 1'b1;
    s_axis_wdata_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_wdata_tdata = beat(32'h10 + 32'(i));
      step();
    end
    s_axis_wdata_tdata = beat(32'h14);
    checks++; if (wdata_level !== 3'd4 || s_axis_wdata_tready !== 1'b0) begin errors++; $display("FAIL full_level: got %0d ready %b expected 4 0", wdata_level, s_axis_wdata_tready); end
    s_axis_instr_tdata = mk(8'h04, 3'd4, 3'd0, 3'd0, 3'd0);
    s_axis_instr_tvalid = 1'b1;
    step();
    ins2 = mk(8'h05, 3'd4, 3'd1, 3'd1, 3'd1);
    s_axis_instr_tdata = ins2;
    checks++; if (m_axis_tvalid !== 1'b1 || slot(m_axis_tdata, 0) !== beat(32'h10)) begin errors++; $display("FAIL full_out1: got tvalid %b slot0 %h expected 1 %h", m_axis_tvalid, slot(m_axis_tdata, 0), beat(32'h10)); end
    checks++; if (s_axis_wdata_tready !== 1'b0 || wdata_level !== 3'd4) begin errors++; $display("FAIL full_nopass: got ready %b level %0d expected 0 4", s_axis_wdata_tready, wdata_level); end
    step();
    s_axis_instr_tvalid = 1'b0;
    checks++; if (wdata_level !== 3'd3 || s_axis_wdata_tready !== 1'b1) begin errors++; $display("FAIL full_pop: got level %0d ready %b expected 3 1", wdata_level, s_axis_wdata_tready); end
    checks++; if (m_axis_tdata[IW-1:0] !== ins2 || slot(m_axis_tdata, 0) !== beat(32'h11)) begin errors++; $display("FAIL full_out2: got slot0 %h expected %h", slot(m_axis_tdata, 0), beat(32'h11)); end
    step();
    s_axis_wdata_tvalid = 1'b0;
    checks++; if (wdata_level !== 3'd3 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL full_pushpop: got level %0d tvalid %b expected 3 0", wdata_level, m_axis_tvalid); end
    s_axis_instr_tdata = mk(8'h06, 3'd4, 3'd4, 3'd4, 3'd0);
    s_axis_instr_tvalid = 1'b1;
    step();
    s_axis_instr_tvalid = 1'b0;
    checks++; if (slot(m_axis_tdata, 0) !== beat(32'h12) || slot(m_axis_tdata, 1) !== beat(32'h13) || slot(m_axis_tdata, 2) !== beat(32'h14)) begin errors++; $display("FAIL full_wrap: got slot2 %h expected %h", slot(m_axis_tdata, 2), beat(32'h14)); end
    step();
    checks++; if (wdata_level !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", wdata_level); end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] h1, h2, h3;
    logic [MW-1:0] held;
    h1 = mk(8'h11, 3'd4, 3'd0, 3'd0, 3'd0);
    h2 = mk(8'h12, 3'd0, 3'd4, 3'd0, 3'd0);
    h3 = mk(8'h13, 3'd0, 3'd0, 3'd0, 3'd0);
    s_axis_wdata_tvalid = 1'b1;
    s_axis_wdata_tdata = beat(32'h21);
    step();
    s_axis_wdata_tdata = beat(32'h22);
    step();
    s_axis_wdata_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_instr_tdata = h1;
    s_axis_instr_tvalid = 1'b1;
    step();
    s_axis_instr_tdata = h2;
    held = m_axis_tdata;
    checks++; if (held[IW-1:0] !== h1 || slot(held, 0) !== beat(32'h21)) begin errors++; $display("FAIL bp_first: got %h expected %h", held[IW-1:0], h1); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held || s_axis_instr_tready !== 1'b0 || wdata_level !== 3'd2) begin errors++; $display("FAIL bp_hold%0d: got tvalid %b itready %b level %0d expected 1 0 2", i, m_axis_tvalid, s_axis_instr_tready, wdata_level); end
    end
    m_axis_tready = 1'b1;
    #1;
    checks++; if (s_axis_instr_tready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", s_axis_instr_tready); end
    step();
    s_axis_instr_tdata = h3;
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata[IW-1:0] !== h2 || slot(m_axis_tdata, 1) !== beat(32'h22) || wdata_level !== 3'd1) begin errors++; $display("FAIL bp_b2b1: got instr %h level %0d expected %h 1", m_axis_tdata[IW-1:0], wdata_level, h2); end
    step();
    s_axis_instr_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata[IW-1:0] !== h3 || wdata_level !== 3'd0) begin errors++; $display("FAIL bp_b2b2: got instr %h level %0d expected %h 0", m_axis_tdata[IW-1:0], wdata_level, h3); end
    step();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_end: got tvalid %b expected 0", m_axis_tvalid); end
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b1;
    s_axis_wdata_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_wdata_tdata = beat(32'h30 + 32'(i));
      step();
    end
    s_axis_wdata_tvalid = 1'b0;
    s_axis_instr_tdata = mk(8'h20, 3'd4, 3'd4, 3'd4, 3'd4);
    s_axis_instr_tvalid = 1'b1;
    step();
    s_axis_instr_tvalid = 1'b0;
    step();
    checks++; if (stall_wdata !== 1'b1 || wdata_level !== 3'd3 || stall_cycles !== 32'd6) begin errors++; $display("FAIL rm_setup: got stall %b level %0d cnt %0d expected 1 3 6", stall_wdata, wdata_level, stall_cycles); end
    rst = 1'b1;
    s_axis_wdata_tvalid = 1'b1;
    s_axis_wdata_tdata = beat(32'h40);
    #1;
    checks++; if (s_axis_wdata_tready !== 1'b0 || s_axis_instr_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rm_during: got %b%b%b expected 000", s_axis_wdata_tready, s_axis_instr_tready, m_axis_tvalid); end
    step();
    rst = 1'b0;
    s_axis_wdata_tvalid = 1'b0;
    step();
    checks++; if (m_axis_tvalid !== 1'b0 || wdata_level !== 3'd0 || stall_cycles !== 32'd0 || stall_wdata !== 1'b0) begin errors++; $display("FAIL rm_after: got tvalid %b level %0d cnt %0d expected 0 0 0", m_axis_tvalid, wdata_level, stall_cycles); end
    s_axis_wdata_tvalid = 1'b1;
    s_axis_wdata_tdata = beat(32'h50);
    s_axis_instr_tdata = mk(8'h21, 3'd4, 3'd0, 3'd0, 3'd0);
    s_axis_instr_tvalid = 1'b1;
    step();
    s_axis_wdata_tvalid = 1'b0;
    s_axis_instr_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1 || slot(m_axis_tdata, 0) !== beat(32'h50) || wdata_level !== 3'd1) begin errors++; $display("FAIL rm_fresh: got slot0 %h level %0d expected %h 1", slot(m_axis_tdata, 0), wdata_level, beat(32'h50)); end
    step();
  endtask

  initial begin
    test_reset();
    test_no_wr();
    test_preload();
    test_underrun();
    test_full();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
